// File: rtl/mult_32bit_ctrl.sv
// Sequential 32x32 unsigned shift-add multiplier with an IDLE/CALC/DONE controller.
// Optional macro ZERO_SKIP_EN: a zero operand finishes in one cycle without entering CALC.
module mult_32bit_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state   // 0=IDLE, 1=CALC, 2=DONE
);

    // Handshake: start is a request sampled only in IDLE; it is taken on the
    // edge where state==IDLE && start==1. done is a one-cycle pulse meaning
    // hi/lo hold the new product; hi/lo then hold until the next accepted start.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [5:0]       count;

    logic [WIDTH-1:0] partial;
    logic [WIDTH:0]   sum;

    // sum[WIDTH] is the carry; shifting right moves it into hi[MSB] and
    // leaves the vacated carry position zero, so no carry register is needed.
    always_comb begin
        partial = mcand & {WIDTH{lo[0]}};
        sum     = {1'b0, hi} + {1'b0, partial};
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            mcand <= '0;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= rs;
                        hi    <= '0;
                        lo    <= rt;
                        count <= '0;
`ifdef ZERO_SKIP_EN
                        if ((rs == '0) || (rt == '0)) begin
                            lo    <= '0;
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= CALC;
                            busy  <= 1'b1;
                        end
`else
                        state <= CALC;
                        busy  <= 1'b1;
`endif
                    end
                end
                CALC: begin
                    hi    <= sum[WIDTH:1];
                    lo    <= {sum[0], lo[WIDTH-1:1]};
                    count <= count + 6'd1;
                    if (count == 6'd31) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_32bit_ctrl.sv
// Directed bench for mult_32bit_ctrl: latency, products, ignored starts,
// mid-operation reset, zero operands and back-to-back operation.
module tb_mult_32bit_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    mult_32bit_ctrl #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rs        (rs),
        .rt        (rt),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

`ifdef ZERO_SKIP_EN
    localparam int ZERO_LAT  = 1;
    localparam int ZERO_BUSY = 0;
`else
    localparam int ZERO_LAT  = 33;
    localparam int ZERO_BUSY = 32;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives start in the current (IDLE) cycle, then follows the operation to
    // the first IDLE cycle after DONE. Operands are scrambled after acceptance.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int exp_lat, input int exp_busy, input bit inject);
        int cyc;
        int busy_cnt;
        int both_cnt;
        rs    = a;
        rt    = b;
        start = 1'b1;
        @(negedge clk);
        cyc      = 1;
        busy_cnt = 0;
        both_cnt = 0;
        while (done !== 1'b1 && cyc < 60) begin
            if (busy === 1'b1) busy_cnt++;
            rs    = $urandom;
            rt    = $urandom;
            start = inject && (cyc == 5 || cyc == 6);
            if (inject && (cyc == 5 || cyc == 6)) begin
                rs = 32'd7;
                rt = 32'd7;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (busy === 1'b1 && done === 1'b1) both_cnt++;
        chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
        chk({tag, "_busy_done_overlap"}, 64'(both_cnt), 64'd0);
        chk({tag, "_hi"}, {32'h0, hi}, {32'h0, exp_hi});
        chk({tag, "_lo"}, {32'h0, lo}, {32'h0, exp_lo});
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, {63'h0, done}, 64'd0);
        chk({tag, "_back_idle"}, {62'h0, dbg_state}, 64'd0);
    endtask

    task automatic hold_check(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        rs = 32'hDEAD_BEEF;
        rt = 32'h1234_5678;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk({tag, "_hold_hi"}, {32'h0, hi}, {32'h0, exp_hi});
        chk({tag, "_hold_lo"}, {32'h0, lo}, {32'h0, exp_lo});
        chk({tag, "_hold_idle"}, {62'h0, dbg_state, busy, done} , 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        rs    = 32'hFFFF_FFFF;
        rt    = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        chk("reset_busy", {63'h0, busy}, 64'd0);
        chk("reset_done", {63'h0, done}, 64'd0);
        chk("reset_hi", {32'h0, hi}, 64'd0);
        chk("reset_lo", {32'h0, lo}, 64'd0);
        chk("reset_state", {62'h0, dbg_state}, 64'd0);

        // Start in the very first cycle after reset deasserts.
        reset = 1'b0;
        run_op("mul_3x5", 32'd3, 32'd5, 32'h0, 32'h0000_000F, 33, 32, 1'b0);
        run_op("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 32, 1'b0);
        hold_check("mul_max", 32'hFFFF_FFFE, 32'h0000_0001);

        run_op("mul_ignore", 32'h0F80_0000, 32'h0000_0010, 32'h0, 32'hF800_0000, 33, 32, 1'b1);
        hold_check("mul_ignore", 32'h0, 32'hF800_0000);

        // Reset in cycle t+10 of a 9*9 operation.
        rs    = 32'd9;
        rt    = 32'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_busy_before_reset", {63'h0, busy}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_busy", {63'h0, busy}, 64'd0);
        chk("mid_reset_done", {63'h0, done}, 64'd0);
        chk("mid_reset_hi", {32'h0, hi}, 64'd0);
        chk("mid_reset_lo", {32'h0, lo}, 64'd0);
        chk("mid_reset_state", {62'h0, dbg_state}, 64'd0);
        reset = 1'b0;
        run_op("mul_2x4", 32'd2, 32'd4, 32'h0, 32'h0000_0008, 33, 32, 1'b0);

        run_op("mul_zero", 32'd0, 32'h1234_5678, 32'h0, 32'h0, ZERO_LAT, ZERO_BUSY, 1'b0);

        // Back-to-back: second start in the IDLE cycle right after DONE.
        run_op("mul_6x7", 32'd6, 32'd7, 32'h0, 32'h0000_002A, 33, 32, 1'b0);
        run_op("mul_b2b", 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0, 33, 32, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
